// File: rtl/prbs6_pkg.sv
// rtl/prbs6_pkg.sv - shared types, tap constants and prediction helpers for the PRBS6 checker
package prbs6_pkg;

   typedef enum logic [1:0] {
      ST_SEED,
      ST_SYNC,
      ST_LOCK
   } state_t;

   localparam int TAP_HI = 6;
   localparam int TAP_LO = 5;

   // Next three generator bits from the current 6-bit history, oldest bit in [3].
   function automatic logic [3:1] prbs6_next3(input logic [6:1] s);
      logic [3:1] p;
      p = '0;
      for (int i = 1; i <= 3; i++) begin
         p[i] = s[TAP_HI - 3 + i] ~^ s[TAP_LO - 3 + i];
      end
      return p;
   endfunction

   function automatic logic [1:0] popcount3(input logic [3:1] m);
      return {1'b0, m[1]} + {1'b0, m[2]} + {1'b0, m[3]};
   endfunction

endpackage

// File: rtl/prbs6_if.sv
// rtl/prbs6_if.sv - word input and status bundle between link source and PRBS6 checker
interface prbs6_if #(
   parameter int ERRW = 16
);
   logic            valid;
   logic [3:1]      din;
   logic            clr_cnt;
   logic            locked;
   logic            err_pulse;
   logic [1:0]      err_bits;
   logic [ERRW-1:0] err_cnt;
   logic            lockup;

   modport master (
      output valid, din, clr_cnt,
      input  locked, err_pulse, err_bits, err_cnt, lockup
   );

   modport slave (
      input  valid, din, clr_cnt,
      output locked, err_pulse, err_bits, err_cnt, lockup
   );
endinterface

// File: rtl/prbs6_err_counter.sv
// rtl/prbs6_err_counter.sv - saturating bit-error accumulator; clear takes effect before the add
module prbs6_err_counter #(
   parameter int ERRW = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            en,
   input  logic [1:0]      add,
   output logic [ERRW-1:0] cnt
);

   logic [ERRW:0] sum;

   always_comb begin
      sum = (clr ? {(ERRW+1){1'b0}} : {1'b0, cnt})
          + (en ? {{(ERRW-1){1'b0}}, add} : {(ERRW+1){1'b0}});
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr || en) begin
         cnt <= sum[ERRW] ? {ERRW{1'b1}} : sum[ERRW-1:0];
      end
   end

endmodule

// File: rtl/prbs6_checker.sv
// rtl/prbs6_checker.sv - self-seeding PRBS6 (x^6+x^5+1, XNOR) receive checker with BER count
// Optional all-ones lockup detection is built when PRBS6_LOCKUP_DET_EN is defined.
module prbs6_checker
   import prbs6_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERRW     = 16
) (
   input logic     clk,
   input logic     reset_n,
   prbs6_if.slave  bus
);

   state_t     state;
   logic [6:1] s;
   logic [3:0] good;
   logic [3:0] bad;
   logic       locked_q;
   logic       err_pulse_q;
   logic [1:0] err_bits_q;

   logic [3:1] pred;
   logic [3:1] mism;
   logic [1:0] mism_bits;
   logic [6:1] s_din;

   always_comb begin
      pred      = prbs6_next3(s);
      mism      = bus.din ^ pred;
      mism_bits = popcount3(mism);
      s_din     = {s[3:1], bus.din};
   end

`ifdef PRBS6_LOCKUP_DET_EN
   logic lockup_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_SEED;
         s           <= '0;
         good        <= '0;
         bad         <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_bits_q  <= 2'd0;
`ifdef PRBS6_LOCKUP_DET_EN
         lockup_q    <= 1'b0;
`endif
      end else begin
         err_pulse_q <= 1'b0;
         if (bus.valid) begin
            err_bits_q <= 2'd0;
            unique case (state)
               ST_SEED: begin
                  s <= s_din;
                  if (good == 4'd1) begin
                     state <= ST_SYNC;
                     good  <= '0;
                  end else begin
                     good <= good + 4'd1;
                  end
               end
               ST_SYNC: begin
                  s <= s_din;
                  if (mism != 3'b000) begin
                     good <= '0;
                  end else if (good == 4'(LOCK_CNT - 1)) begin
                     state    <= ST_LOCK;
                     locked_q <= 1'b1;
                     bad      <= '0;
                     good     <= '0;
`ifdef PRBS6_LOCKUP_DET_EN
                     lockup_q <= 1'b0;
`endif
                  end else begin
                     good <= good + 4'd1;
                  end
`ifdef PRBS6_LOCKUP_DET_EN
                  // All-ones is the XNOR fixed point: refuse to count it as clean.
                  if (s_din == 6'b111111) begin
                     state    <= ST_SYNC;
                     locked_q <= 1'b0;
                     good     <= '0;
                     lockup_q <= 1'b1;
                  end
`endif
               end
               ST_LOCK: begin
                  // Free-run the reference so a flipped bit costs one error, not a burst.
                  s           <= {s[3:1], pred};
                  err_bits_q  <= mism_bits;
                  err_pulse_q <= |mism;
                  if (mism != 3'b000) begin
                     if (bad == 4'(LOSS_CNT - 1)) begin
                        state    <= ST_SYNC;
                        locked_q <= 1'b0;
                        good     <= '0;
                        bad      <= '0;
                     end else begin
                        bad <= bad + 4'd1;
                     end
                  end else begin
                     bad <= '0;
                  end
               end
               default: state <= ST_SEED;
            endcase
         end
      end
   end

   prbs6_err_counter #(
      .ERRW (ERRW)
   ) u_err_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (bus.clr_cnt),
      .en      (bus.valid && (state == ST_LOCK)),
      .add     (mism_bits),
      .cnt     (bus.err_cnt)
   );

   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_bits  = err_bits_q;
`ifdef PRBS6_LOCKUP_DET_EN
   assign bus.lockup    = lockup_q;
`else
   assign bus.lockup    = 1'b0;
`endif

endmodule

// File: tb/tb_prbs6_checker.sv
// tb/tb_prbs6_checker.sv - directed self-checking bench for prbs6_checker (ERRW=4)
module tb_prbs6_checker;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_asrt = 0;
   int   n_fail = 0;
   logic [6:1] g = '0;

   always #5 clk = ~clk;

   prbs6_if #(.ERRW(4)) bus ();

   prbs6_checker #(
      .LOCK_CNT (4),
      .LOSS_CNT (3),
      .ERRW     (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [3:1] d, input logic c);
      bus.valid   = v;
      bus.din     = d;
      bus.clr_cnt = c;
      @(posedge clk);
      #1;
      bus.valid   = 1'b0;
      bus.clr_cnt = 1'b0;
   endtask

   task automatic gen(output logic [3:1] w);
      w = {g[5] ~^ g[6], g[4] ~^ g[5], g[3] ~^ g[4]};
      g = {g[3:1], w};
   endtask

   task automatic send(input logic [3:1] flip, input logic c);
      logic [3:1] w;
      gen(w);
      step(1'b1, w ^ flip, c);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 3'b000, 1'b0);
      end
   endtask

   initial begin
      bus.valid   = 1'b0;
      bus.din     = 3'b000;
      bus.clr_cnt = 1'b0;

      // Reset state
      reset_n = 1'b0;
      idle(2);
      check("rst_locked", bus.locked, 0);
      check("rst_err_pulse", bus.err_pulse, 0);
      check("rst_err_bits", bus.err_bits, 0);
      check("rst_err_cnt", bus.err_cnt, 0);
      check("rst_lockup", bus.lockup, 0);
      reset_n = 1'b1;

      // 1: first words are hand-computed 111, 110 from state 0; lock on the 6th
      step(1'b1, 3'b111, 1'b0);
      check("t1_w1_locked", bus.locked, 0);
      step(1'b1, 3'b110, 1'b0);
      check("t1_w2_locked", bus.locked, 0);
      g = 6'b111110;
      for (int i = 3; i <= 5; i++) begin
         send(3'b000, 1'b0);
         check($sformatf("t1_w%0d_locked", i), bus.locked, 0);
      end
      send(3'b000, 1'b0);
      check("t1_w6_locked", bus.locked, 1);
      check("t1_err_cnt", bus.err_cnt, 0);
      send(3'b000, 1'b0);
      check("t1_clean_pulse", bus.err_pulse, 0);

      // 2: single flipped middle bit
      send(3'b010, 1'b0);
      check("t2_err_bits", bus.err_bits, 1);
      check("t2_err_pulse", bus.err_pulse, 1);
      check("t2_err_cnt", bus.err_cnt, 1);
      check("t2_locked", bus.locked, 1);
      idle(1);
      check("t2_pulse_gap", bus.err_pulse, 0);
      check("t2_cnt_gap", bus.err_cnt, 1);
      send(3'b000, 1'b0);
      check("t2_pulse_clean", bus.err_pulse, 0);
      send(3'b000, 1'b1);
      check("t2_clr", bus.err_cnt, 0);

      // 3: three fully corrupted words drop lock; four clean words relock
      send(3'b111, 1'b0);
      check("t3_c1_cnt", bus.err_cnt, 3);
      check("t3_c1_locked", bus.locked, 1);
      send(3'b111, 1'b0);
      check("t3_c2_cnt", bus.err_cnt, 6);
      check("t3_c2_locked", bus.locked, 1);
      send(3'b111, 1'b0);
      check("t3_c3_cnt", bus.err_cnt, 9);
      check("t3_c3_bits", bus.err_bits, 3);
      check("t3_c3_locked", bus.locked, 0);
      for (int i = 1; i <= 3; i++) begin
         send(3'b000, 1'b0);
         check($sformatf("t3_relock%0d", i), bus.locked, 0);
      end
      send(3'b000, 1'b0);
      check("t3_relock4", bus.locked, 1);
      check("t3_cnt_kept", bus.err_cnt, 9);

      // 5: saturation at 4'hF; errored words interleaved with clean ones keep lock
      send(3'b000, 1'b1);
      check("t5_clr", bus.err_cnt, 0);
      for (int i = 0; i < 4; i++) begin
         send(3'b111, 1'b0);
         send(3'b000, 1'b0);
      end
      check("t5_cnt12", bus.err_cnt, 12);
      send(3'b111, 1'b0);
      check("t5_cnt15", bus.err_cnt, 15);
      send(3'b000, 1'b0);
      send(3'b001, 1'b0);
      check("t5_sat16", bus.err_cnt, 15);
      send(3'b000, 1'b0);
      send(3'b100, 1'b0);
      check("t5_sat17", bus.err_cnt, 15);
      check("t5_locked", bus.locked, 1);
      send(3'b011, 1'b1);
      check("t5_clr_add", bus.err_cnt, 2);

      // Reset in LOCK with an errored word present clears every output
      reset_n = 1'b0;
      send(3'b111, 1'b0);
      check("rl_locked", bus.locked, 0);
      check("rl_err_pulse", bus.err_pulse, 0);
      check("rl_err_bits", bus.err_bits, 0);
      check("rl_err_cnt", bus.err_cnt, 0);
      check("rl_lockup", bus.lockup, 0);
      reset_n = 1'b1;

      // 4: gaps of 1..5 idle cycles between words
      g = '0;
      for (int i = 1; i <= 5; i++) begin
         send(3'b000, 1'b0);
         check($sformatf("t4_w%0d_locked", i), bus.locked, 0);
         for (int k = 0; k < i; k++) begin
            idle(1);
            check("t4_gap_pulse", bus.err_pulse, 0);
         end
         check($sformatf("t4_gap%0d_locked", i), bus.locked, 0);
      end
      send(3'b000, 1'b0);
      check("t4_w6_locked", bus.locked, 1);
      check("t4_err_cnt", bus.err_cnt, 0);

      // 6: constant all-ones input
      reset_n = 1'b0;
      idle(1);
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 3'b111, 1'b0);
         check($sformatf("t6_w%0d_locked", i), bus.locked, 0);
      end
`ifdef PRBS6_LOCKUP_DET_EN
      for (int i = 6; i <= 9; i++) begin
         step(1'b1, 3'b111, 1'b0);
         check($sformatf("t6_w%0d_locked", i), bus.locked, 0);
      end
      check("t6_lockup", bus.lockup, 1);
`else
      step(1'b1, 3'b111, 1'b0);
      check("t6_w6_locked", bus.locked, 1);
      check("t6_lockup", bus.lockup, 0);
      step(1'b1, 3'b111, 1'b0);
      check("t6_err_cnt", bus.err_cnt, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
